// File: rtl/pool_arbiter_if.sv
// pool_arbiter_if: bundles the unit request/grant bus and the conveyor word
// interface of pool_arbiter.
//   master : requesting units plus conveyor (drive requests and ready,
//            observe grants, conveyor word and conflict counter)
//   slave  : the arbiter itself
// Bit maps: unit u, slot s -> request/grant bit u*NS+s,
//           stamp data [u*NS*3+s*3 +: 3], take data [u*NS*5+s*5 +: 5].
interface pool_arbiter_if #(
    parameter int NU = 5,
    parameter int NS = 8,
    parameter int CW = 16
);
    logic [NU*NS*3-1:0] req_stamp_flat;
    logic [NU*NS-1:0]   req_stamp_in;
    logic [NU*NS*5-1:0] req_take_flat;
    logic [NU*NS-1:0]   req_take_in;
    logic [NU*NS-1:0]   stamp_gnt;
    logic [NU*NS-1:0]   take_gnt;
    logic               conveyor_ready;
    logic [NS*3-1:0]    conveyor_stamp_flat;
    logic [NS-1:0]      conveyor_stamp_in;
    logic [NS*5-1:0]    conveyor_take_flat;
    logic [NS-1:0]      conveyor_take_in;
    logic [CW-1:0]      conflict_cnt;

    modport master (
        output req_stamp_flat, req_stamp_in, req_take_flat, req_take_in,
        output conveyor_ready,
        input  stamp_gnt, take_gnt,
        input  conveyor_stamp_flat, conveyor_stamp_in,
        input  conveyor_take_flat, conveyor_take_in,
        input  conflict_cnt
    );

    modport slave (
        input  req_stamp_flat, req_stamp_in, req_take_flat, req_take_in,
        input  conveyor_ready,
        output stamp_gnt, take_gnt,
        output conveyor_stamp_flat, conveyor_stamp_in,
        output conveyor_take_flat, conveyor_take_in,
        output conflict_cnt
    );
endinterface

// File: rtl/pool_arbiter.sv
// pool_arbiter: per-slot round-robin merge of stamp/take requests from five
// execution units (0=alu 1=fpu 2=imm 3=jump 4=mov) into one registered,
// held-until-accepted conveyor word.
// Ports:
//   clk    - clock
//   rst_n  - asynchronous active-low reset
//   bus    - pool_arbiter_if.slave: requests in, combinational grants out,
//            registered conveyor word out, saturating conflict counter out
module pool_arbiter #(
    parameter int NU = 5,
    parameter int NS = 8,
    parameter int CW = 16
) (
    input logic          clk,
    input logic          rst_n,
    pool_arbiter_if.slave bus
);
    localparam int PW = 3;  // pointer / unit index width
    localparam int SW = 3;  // stamp data width
    localparam int TW = 5;  // take data width

    logic [PW-1:0]    stamp_ptr_q [NS];
    logic [PW-1:0]    take_ptr_q  [NS];
    logic [NS*SW-1:0] cstamp_flat_q, cstamp_flat_d;
    logic [NS-1:0]    cstamp_vld_q,  cstamp_vld_d;
    logic [NS*TW-1:0] ctake_flat_q,  ctake_flat_d;
    logic [NS-1:0]    ctake_vld_q,   ctake_vld_d;
    logic [CW-1:0]    cnt_q,         cnt_d;

    logic [NS-1:0]    st_found, tk_found;
    logic [PW-1:0]    st_win [NS];
    logic [PW-1:0]    tk_win [NS];
    logic             empty, load_en, any_deny;

    // First requester at or after ptr, wrapping modulo NU. Returns {found, winner}.
    function automatic logic [PW:0] rr_pick(input logic [NU-1:0] req,
                                            input logic [PW-1:0] ptr);
        logic          found;
        logic [PW-1:0] win;
        int            u;
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < NU; k++) begin
            u = int'(ptr) + k;
            if (u >= NU) u = u - NU;
            if (!found && req[u]) begin
                found = 1'b1;
                win   = PW'(u);
            end
        end
        return {found, win};
    endfunction

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] win);
        return (win == PW'(NU - 1)) ? '0 : win + PW'(1);
    endfunction

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + CW'(1);
    endfunction

    // Grants are suppressed while in reset so units never see a grant that
    // could not be loaded.
    assign empty   = ~|{cstamp_vld_q, ctake_vld_q};
    assign load_en = rst_n & (bus.conveyor_ready | empty);

    always_comb begin
        logic [NU-1:0] rv_s;
        logic [NU-1:0] rv_t;
        st_found = '0;
        tk_found = '0;
        for (int s = 0; s < NS; s++) begin
            rv_s = '0;
            rv_t = '0;
            for (int u = 0; u < NU; u++) begin
                rv_s[u] = bus.req_stamp_in[u*NS + s];
                rv_t[u] = bus.req_take_in[u*NS + s];
            end
            {st_found[s], st_win[s]} = rr_pick(rv_s, stamp_ptr_q[s]);
            {tk_found[s], tk_win[s]} = rr_pick(rv_t, take_ptr_q[s]);
        end
    end

    always_comb begin
        bus.stamp_gnt  = '0;
        bus.take_gnt   = '0;
        cstamp_flat_d  = '0;
        cstamp_vld_d   = '0;
        ctake_flat_d   = '0;
        ctake_vld_d    = '0;
        for (int s = 0; s < NS; s++) begin
            if (st_found[s]) begin
                bus.stamp_gnt[int'(st_win[s])*NS + s] = load_en;
                cstamp_vld_d[s] = 1'b1;
                cstamp_flat_d[s*SW +: SW] =
                    bus.req_stamp_flat[int'(st_win[s])*NS*SW + s*SW +: SW];
            end
            if (tk_found[s]) begin
                bus.take_gnt[int'(tk_win[s])*NS + s] = load_en;
                ctake_vld_d[s] = 1'b1;
                ctake_flat_d[s*TW +: TW] =
                    bus.req_take_flat[int'(tk_win[s])*NS*TW + s*TW +: TW];
            end
        end
    end

    // A stall (load_en=0) denies every pending request and therefore counts.
    assign any_deny = (|(bus.req_stamp_in & ~bus.stamp_gnt)) |
                      (|(bus.req_take_in  & ~bus.take_gnt));
    assign cnt_d    = any_deny ? sat_inc(cnt_q) : cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cstamp_flat_q <= '0;
            cstamp_vld_q  <= '0;
            ctake_flat_q  <= '0;
            ctake_vld_q   <= '0;
            cnt_q         <= '0;
            for (int s = 0; s < NS; s++) begin
                stamp_ptr_q[s] <= '0;
                take_ptr_q[s]  <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
            if (load_en) begin
                cstamp_flat_q <= cstamp_flat_d;
                cstamp_vld_q  <= cstamp_vld_d;
                ctake_flat_q  <= ctake_flat_d;
                ctake_vld_q   <= ctake_vld_d;
                for (int s = 0; s < NS; s++) begin
                    if (st_found[s]) stamp_ptr_q[s] <= ptr_next(st_win[s]);
                    if (tk_found[s]) take_ptr_q[s]  <= ptr_next(tk_win[s]);
                end
            end
        end
    end

    assign bus.conveyor_stamp_flat = cstamp_flat_q;
    assign bus.conveyor_stamp_in   = cstamp_vld_q;
    assign bus.conveyor_take_flat  = ctake_flat_q;
    assign bus.conveyor_take_in    = ctake_vld_q;
    assign bus.conflict_cnt        = cnt_q;
endmodule
